pcie_phy_reset_seq: RTL and testbench

//  PHY bring-up reset sequencer: consumes clk and the synchronized reset from the clock/reset generator.

---
 rtl/pcie_phy_pkg.sv | 28 ++
 rtl/pcie_sync_2ff.sv | 29 ++
 rtl/pcie_phy_reset_seq.sv | 151 +++++++++++++++
 tb/tb_pcie_phy_reset_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared types and sizing helpers for the PCIe PHY reset sequencer.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        RST_PLL  = 3'd0,
        WAIT_PLL = 3'd1,
        WAIT_CDR = 3'd2,
        RST_PCS  = 3'd3,
        READY    = 3'd4,
        ERROR    = 3'd5
    } phy_rst_state_e;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pcie_sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronously reset to 0.
module pcie_sync_2ff (
    input  logic clk,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pcie_phy_reset_seq.sv
// PHY bring-up reset sequencer: PLL reset -> PLL lock -> PMA release -> CDR lock
// -> PCS release -> ready, with bounded retries on lock timeout.
module pcie_phy_reset_seq
    import pcie_phy_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES   = 16,
    parameter int unsigned PLL_LOCK_TIMEOUT = 1024,
    parameter int unsigned CDR_LOCK_TIMEOUT = 1024,
    parameter int unsigned PCS_RST_CYCLES   = 8,
    parameter int unsigned MAX_RETRIES      = 3
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       restart_i,
    input  logic       pll_lock_i,
    input  logic       cdr_lock_i,
    output logic       pll_rst_o,
    output logic       pma_rst_o,
    output logic       pcs_rst_o,
    output logic       phy_ready_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    localparam int unsigned CW = cnt_width(max4(PLL_LOCK_TIMEOUT, CDR_LOCK_TIMEOUT,
                                                PLL_RST_CYCLES, PCS_RST_CYCLES));
    localparam int unsigned RW = cnt_width(MAX_RETRIES + 1);

    localparam logic [CW-1:0] PLL_RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] PLL_LOCK_LAST = CW'(PLL_LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CDR_LOCK_LAST = CW'(CDR_LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] PCS_RST_LAST  = CW'(PCS_RST_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST    = RW'(MAX_RETRIES);

    logic pll_lock_s, cdr_lock_s;

    phy_rst_state_e  state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            timeout;
    logic            pll_rst_q, pll_rst_d;
    logic            pma_rst_q, pma_rst_d;
    logic            pcs_rst_q, pcs_rst_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    pcie_sync_2ff u_pll_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .d_i   (pll_lock_i),
        .q_o   (pll_lock_s)
    );

    pcie_sync_2ff u_cdr_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .d_i   (cdr_lock_i),
        .q_o   (cdr_lock_s)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            pma_rst_q <= 1'b1;
            pcs_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            pma_rst_q <= pma_rst_d;
            pcs_rst_q <= pcs_rst_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // RETRY is resolved inline: a timeout either bumps retry and restarts, or lands in ERROR.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        timeout = 1'b0;
        if (restart_i) begin
            state_d = RST_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: begin
                    if (cnt_q == PLL_RST_LAST) state_d = WAIT_PLL;
                end
                WAIT_PLL: begin
                    if (pll_lock_s)                  state_d = WAIT_CDR;
                    else if (cnt_q == PLL_LOCK_LAST) timeout = 1'b1;
                end
                WAIT_CDR: begin
                    if (!pll_lock_s)                 state_d = RST_PLL;
                    else if (cdr_lock_s)             state_d = RST_PCS;
                    else if (cnt_q == CDR_LOCK_LAST) timeout = 1'b1;
                end
                RST_PCS: begin
                    if (!pll_lock_s)      state_d = RST_PLL;
                    else if (!cdr_lock_s) state_d = WAIT_CDR;
                    else if (cnt_q == PCS_RST_LAST) begin
                        state_d = READY;
                        retry_d = '0;
                    end
                end
                READY: begin
                    if (!pll_lock_s)      state_d = RST_PLL;
                    else if (!cdr_lock_s) state_d = WAIT_CDR;
                end
                ERROR:   state_d = ERROR;
                default: state_d = RST_PLL;
            endcase
        end

        if (timeout) begin
            if (retry_q == RETRY_LAST) begin
                state_d = ERROR;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = RST_PLL;
            end
        end

        if (restart_i || (state_d != state_q)) cnt_d = '0;
        else if (cnt_q != '1)                   cnt_d = cnt_q + 1'b1;
        else                                    cnt_d = cnt_q;
    end

    always_comb begin
        pll_rst_d = (state_d == RST_PLL) || (state_d == ERROR);
        pma_rst_d = (state_d == RST_PLL) || (state_d == WAIT_PLL) || (state_d == ERROR);
        pcs_rst_d = (state_d != READY);
        ready_d   = (state_d == READY);
        err_d     = (state_d == ERROR);
    end

    assign pll_rst_o   = pll_rst_q;
    assign pma_rst_o   = pma_rst_q;
    assign pcs_rst_o   = pcs_rst_q;
    assign phy_ready_o = ready_q;
    assign err_o       = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pcie_phy_reset_seq.sv
// Table-driven bench for pcie_phy_reset_seq with a queue scoreboard.
module tb_pcie_phy_reset_seq;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       restart_i = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       cdr_lock_i = 1'b0;
    logic       pll_rst_o, pma_rst_o, pcs_rst_o, phy_ready_o, err_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    pcie_phy_reset_seq #(
        .PLL_RST_CYCLES   (16),
        .PLL_LOCK_TIMEOUT (32),
        .CDR_LOCK_TIMEOUT (64),
        .PCS_RST_CYCLES   (8),
        .MAX_RETRIES      (3)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .restart_i   (restart_i),
        .pll_lock_i  (pll_lock_i),
        .cdr_lock_i  (cdr_lock_i),
        .pll_rst_o   (pll_rst_o),
        .pma_rst_o   (pma_rst_o),
        .pcs_rst_o   (pcs_rst_o),
        .phy_ready_o (phy_ready_o),
        .err_o       (err_o),
        .state_o     (state_o)
    );

    // Expected output bundles {pll_rst, pma_rst, pcs_rst, ready, err}
    localparam logic [4:0] O_RSTPLL = 5'b11100;
    localparam logic [4:0] O_WPLL   = 5'b01100;
    localparam logic [4:0] O_WCDR   = 5'b00100;
    localparam logic [4:0] O_READY  = 5'b00010;
    localparam logic [4:0] O_ERR    = 5'b11101;

    typedef struct {
        logic       rst;
        logic       restart;
        logic       pll;
        logic       cdr;
        int         cycles;
        logic [2:0] st;
        logic [4:0] outs;
    } vec_t;

    typedef struct {
        logic [7:0] v;
        string      name;
    } exp_t;

    vec_t tab[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic restart, input logic pll, input logic cdr,
                       input int cycles, input logic [2:0] st, input logic [4:0] outs);
        vec_t v;
        v.rst = rst; v.restart = restart; v.pll = pll; v.cdr = cdr;
        v.cycles = cycles; v.st = st; v.outs = outs;
        tab.push_back(v);
    endtask

    function automatic logic [7:0] dut_obs();
        return {state_o, pll_rst_o, pma_rst_o, pcs_rst_o, phy_ready_o, err_o};
    endfunction

    task automatic push_exp(input logic [7:0] v, input string name);
        exp_t e;
        e.v = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic check_pop(input logic [7:0] act);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got state=%0d outs=%b, no expectation queued",
                     act[7:5], act[4:0]);
        end else begin
            e = exp_q.pop_front();
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                         e.name, act[7:5], act[4:0], e.v[7:5], e.v[4:0]);
            end
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rst_i      = tab[i].rst;
            restart_i  = tab[i].restart;
            pll_lock_i = tab[i].pll;
            cdr_lock_i = tab[i].cdr;
            push_exp({tab[i].st, tab[i].outs}, $sformatf("vec%0d", i));
            repeat (tab[i].cycles) @(posedge clk);
            @(negedge clk);
            check_pop(dut_obs());
        end
    endtask

    task automatic add_nominal_tail();
        add(0, 0, 1, 1, 15, 3'd0, O_RSTPLL);
        add(0, 0, 1, 1, 1,  3'd1, O_WPLL);
        add(0, 0, 1, 1, 1,  3'd2, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 7,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd4, O_READY);
    endtask

    initial begin
        int split;

        // Nominal bring-up: pll lock after edge 40, cdr lock after edge 80
        add(1, 0, 0, 0, 2,  3'd0, O_RSTPLL);
        add(0, 0, 0, 0, 15, 3'd0, O_RSTPLL);
        add(0, 0, 0, 0, 1,  3'd1, O_WPLL);
        add(0, 0, 0, 0, 24, 3'd1, O_WPLL);
        add(0, 0, 1, 0, 2,  3'd1, O_WPLL);
        add(0, 0, 1, 0, 1,  3'd2, O_WCDR);
        add(0, 0, 1, 0, 37, 3'd2, O_WCDR);
        add(0, 0, 1, 1, 2,  3'd2, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 7,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd4, O_READY);
        add(0, 0, 1, 1, 5,  3'd4, O_READY);
        // CDR loss for 20 cycles while READY
        add(0, 0, 1, 0, 2,  3'd4, O_READY);
        add(0, 0, 1, 0, 1,  3'd2, O_WCDR);
        add(0, 0, 1, 0, 17, 3'd2, O_WCDR);
        add(0, 0, 1, 1, 2,  3'd2, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 7,  3'd3, O_WCDR);
        add(0, 0, 1, 1, 1,  3'd4, O_READY);
        // Simultaneous PLL and CDR loss: PLL loss wins
        add(0, 0, 0, 0, 2,  3'd4, O_READY);
        add(0, 0, 0, 0, 1,  3'd0, O_RSTPLL);
        add_nominal_tail();
        // Park in WAIT_CDR for the asynchronous reset check
        add(0, 0, 1, 0, 3,  3'd2, O_WCDR);
        split = tab.size();

        // Full sequence after reset with both locks already present
        add(1, 0, 1, 1, 2,  3'd0, O_RSTPLL);
        add_nominal_tail();
        // PLL never locks: four 48-cycle attempts, then sticky ERROR at edge 192
        add(1, 0, 0, 0, 2,   3'd0, O_RSTPLL);
        add(0, 0, 0, 0, 47,  3'd1, O_WPLL);
        add(0, 0, 0, 0, 1,   3'd0, O_RSTPLL);
        add(0, 0, 0, 0, 15,  3'd0, O_RSTPLL);
        add(0, 0, 0, 0, 1,   3'd1, O_WPLL);
        add(0, 0, 0, 0, 127, 3'd1, O_WPLL);
        add(0, 0, 0, 0, 1,   3'd5, O_ERR);
        add(0, 0, 0, 0, 20,  3'd5, O_ERR);
        add(0, 0, 1, 1, 4,   3'd5, O_ERR);
        // Restart out of ERROR, then nominal timing to READY
        add(0, 1, 1, 1, 1,   3'd0, O_RSTPLL);
        add_nominal_tail();

        @(negedge clk);
        run(0, split);

        // Asynchronous reset mid-cycle: outputs must clear before the next clk edge
        #2 rst_i = 1'b1;
        push_exp({3'd0, O_RSTPLL}, "async_rst_wait_cdr");
        #1 check_pop(dut_obs());
        @(negedge clk);

        run(split, tab.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
